ahb3lite_cmd_master: RTL and testbench

//  AHB3-lite bus master driven by a simple valid/ready command port; issues single read/write transfers

---
 rtl/ahb3lite_cmd_master.sv | 123 ++++++++++++
 tb/tb_ahb3lite_cmd_master.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ahb3lite_cmd_master.sv
// ahb3lite_cmd_master: valid/ready command port to single AHB3-lite transfers; AHB3_CMD_MASTER_TIMEOUT_EN adds a data-phase timeout
module ahb3lite_cmd_master #(
  parameter int         HADDR_SIZE = 32,
  parameter logic [3:0] HPROT_VAL  = 4'b0011,
  parameter int         TIMEOUT    = 1024
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [2:0]            cmd_size,
  input  logic [HADDR_SIZE-1:0] cmd_addr,
  input  logic [31:0]           cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy,
  output logic [HADDR_SIZE-1:0] HADDR,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic [1:0]            HTRANS,
  output logic                  HMASTLOCK,
  output logic [31:0]           HWDATA,
  input  logic [31:0]           HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP
);
`ifdef AHB3_CMD_MASTER_TIMEOUT_EN
  typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, HUNG} state_t;
`else
  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
`endif
  state_t state, state_nxt;
  logic accept, legal;
  logic [31:0] wdata_rep, lane, rdata_sz;
  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  assign rsp_valid = state == RESP;
  assign accept = cmd_valid && cmd_ready;
  assign legal = cmd_size == 3'd0 || (cmd_size == 3'd1 && !cmd_addr[0]) || (cmd_size == 3'd2 && cmd_addr[1:0] == 2'b00);
  assign HBURST = 3'b000;
  assign HPROT = HPROT_VAL;
  assign HMASTLOCK = 1'b0;
  assign wdata_rep = cmd_size == 3'd0 ? {4{cmd_wdata[7:0]}} : cmd_size == 3'd1 ? {2{cmd_wdata[15:0]}} : cmd_wdata;
  assign lane = HRDATA >> {HADDR[1:0], 3'b000};
  assign rdata_sz = HSIZE == 3'd0 ? {24'd0, lane[7:0]} : HSIZE == 3'd1 ? {16'd0, lane[15:0]} : lane;
`ifdef AHB3_CMD_MASTER_TIMEOUT_EN
  logic [15:0] stall_cnt;
  logic hung, expired;
  assign expired = state == DATA && !HREADY && stall_cnt == 16'(TIMEOUT - 1);
  // count consecutive data-phase stalls; remember a timeout so the stalled slave is drained afterwards
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      stall_cnt <= '0;
      hung <= 1'b0;
    end else if (accept) begin
      stall_cnt <= '0;
      hung <= 1'b0;
    end else if (state == DATA && !HREADY) begin
      stall_cnt <= stall_cnt + 16'd1;
      if (expired) hung <= 1'b1;
    end
`endif
  // state register
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) state <= IDLE;
    else state <= state_nxt;
  // next-state: one transfer at a time, illegal commands answered without touching the bus
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = legal ? ADDR : RESP;
      ADDR: if (HREADY) state_nxt = DATA;
`ifdef AHB3_CMD_MASTER_TIMEOUT_EN
      DATA: if (HREADY || expired) state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = hung ? HUNG : IDLE;
      HUNG: if (HREADY) state_nxt = IDLE;
`else
      DATA: if (HREADY) state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end
  // registered bus outputs and response capture
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      HTRANS <= 2'b00;
      HADDR <= '0;
      HWRITE <= 1'b0;
      HSIZE <= 3'd0;
      HWDATA <= 32'd0;
      rsp_rdata <= 32'd0;
      rsp_err <= 1'b0;
    end else begin
      if (accept) begin
        HTRANS <= legal ? 2'b10 : 2'b00;
        rsp_err <= !legal;
        rsp_rdata <= 32'd0;
        if (legal) begin
          HADDR <= cmd_addr;
          HWRITE <= cmd_write;
          HSIZE <= cmd_size;
          if (cmd_write) HWDATA <= wdata_rep;
        end
      end
      if (state == ADDR && HREADY) HTRANS <= 2'b00;
      if (state == DATA && HREADY) begin
        rsp_err <= HRESP;
        rsp_rdata <= HWRITE ? 32'd0 : rdata_sz;
      end
`ifdef AHB3_CMD_MASTER_TIMEOUT_EN
      if (expired) begin
        rsp_err <= 1'b1;
        rsp_rdata <= 32'd0;
      end
`endif
    end
endmodule

// File: tb/tb_ahb3lite_cmd_master.sv
// tb_ahb3lite_cmd_master: table-driven bench for ahb3lite_cmd_master plus hand-written stall/reset/timeout sequences
module tb_ahb3lite_cmd_master;
  logic HCLK = 1'b0, HRESETn = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [2:0] cmd_size = 3'd0;
  logic [31:0] cmd_addr = 32'd0, cmd_wdata = 32'd0;
  logic rsp_valid, rsp_ready = 1'b1, rsp_err, busy;
  logic [31:0] rsp_rdata;
  logic [31:0] HADDR, HWDATA, HRDATA = 32'd0;
  logic HWRITE, HMASTLOCK, HREADY = 1'b1, HRESP = 1'b0;
  logic [2:0] HSIZE, HBURST;
  logic [3:0] HPROT;
  logic [1:0] HTRANS;
  int checks = 0, errors = 0;

  ahb3lite_cmd_master #(.HADDR_SIZE(32), .HPROT_VAL(4'b0011), .TIMEOUT(8)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_size(cmd_size),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
    .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] hrdata;
    int          wa;
    int          wd;
    logic        slv_err;
    logic        illegal;
    logic [31:0] exp_hwdata;
    logic [31:0] exp_rdata;
  } vec_t;

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".htrans"}, HTRANS, 32'd0);
    chk({tag, ".haddr"}, HADDR, 32'd0);
    chk({tag, ".hwrite"}, HWRITE, 32'd0);
    chk({tag, ".hsize"}, HSIZE, 32'd0);
    chk({tag, ".hwdata"}, HWDATA, 32'd0);
    chk({tag, ".rsp_valid"}, rsp_valid, 32'd0);
    chk({tag, ".rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, ".rsp_err"}, rsp_err, 32'd0);
    chk({tag, ".busy"}, busy, 32'd0);
    chk({tag, ".cmd_ready"}, cmd_ready, 32'd1);
  endtask

  task automatic run(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_size = v.size; cmd_addr = v.addr; cmd_wdata = v.wdata;
    rsp_ready = 1'b1; HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'hBAD0BAD0;
    chk({tag, ".cmd_ready"}, cmd_ready, 32'd1);
    step();
    cmd_valid = 1'b0;
    if (v.illegal) begin
      chk({tag, ".htrans_none"}, HTRANS, 32'd0);
      chk({tag, ".rsp_valid"}, rsp_valid, 32'd1);
      chk({tag, ".rsp_err"}, rsp_err, 32'd1);
      chk({tag, ".rsp_rdata"}, rsp_rdata, 32'd0);
      step();
      chk({tag, ".rsp_done"}, rsp_valid, 32'd0);
      chk({tag, ".idle"}, cmd_ready, 32'd1);
      return;
    end
    chk({tag, ".nonseq"}, HTRANS, 32'd2);
    chk({tag, ".haddr"}, HADDR, v.addr);
    chk({tag, ".hwrite"}, HWRITE, {31'd0, v.wr});
    chk({tag, ".hsize"}, HSIZE, {29'd0, v.size});
    chk({tag, ".busy"}, busy, 32'd1);
    for (int i = 0; i < v.wa; i++) begin
      HREADY = 1'b0;
      step();
      chk({tag, ".addr_hold"}, HTRANS, 32'd2);
    end
    HREADY = 1'b1;
    step();
    chk({tag, ".data_idle"}, HTRANS, 32'd0);
    if (v.wr) chk({tag, ".hwdata"}, HWDATA, v.exp_hwdata);
    for (int i = 0; i < v.wd; i++) begin
      HREADY = 1'b0;
      HRESP = v.slv_err && i == v.wd - 1;
      step();
      chk({tag, ".wait_no_rsp"}, rsp_valid, 32'd0);
      chk({tag, ".wait_idle"}, HTRANS, 32'd0);
      if (v.wr) chk({tag, ".hwdata_hold"}, HWDATA, v.exp_hwdata);
    end
    HREADY = 1'b1; HRESP = v.slv_err; HRDATA = v.hrdata;
    step();
    HRESP = 1'b0; HRDATA = 32'hBAD0BAD0;
    chk({tag, ".rsp_valid"}, rsp_valid, 32'd1);
    chk({tag, ".rsp_rdata"}, rsp_rdata, v.exp_rdata);
    chk({tag, ".rsp_err"}, rsp_err, {31'd0, v.slv_err});
    chk({tag, ".no_accept"}, cmd_ready, 32'd0);
    step();
    chk({tag, ".rsp_done"}, rsp_valid, 32'd0);
    chk({tag, ".idle"}, cmd_ready, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[12];
    vecs[0]  = '{1'b1, 3'd2, 32'h2000_0010, 32'hDEADBEEF, 32'h0,         0, 0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0};
    vecs[1]  = '{1'b0, 3'd0, 32'h0000_0003, 32'h0,         32'h11223344, 0, 0, 1'b0, 1'b0, 32'h0,         32'h00000011};
    vecs[2]  = '{1'b0, 3'd1, 32'h0000_0002, 32'h0,         32'h11223344, 0, 0, 1'b0, 1'b0, 32'h0,         32'h00001122};
    vecs[3]  = '{1'b1, 3'd0, 32'h0000_0001, 32'h1234565A, 32'h0,         0, 3, 1'b0, 1'b0, 32'h5A5A5A5A, 32'h0};
    vecs[4]  = '{1'b0, 3'd2, 32'h0000_0008, 32'h0,         32'hCAFEF00D, 2, 1, 1'b0, 1'b0, 32'h0,         32'hCAFEF00D};
    vecs[5]  = '{1'b0, 3'd0, 32'h0000_0000, 32'h0,         32'h11223344, 0, 0, 1'b0, 1'b0, 32'h0,         32'h00000044};
    vecs[6]  = '{1'b1, 3'd1, 32'h0000_0006, 32'hAAAABEEF, 32'h0,         1, 0, 1'b0, 1'b0, 32'hBEEFBEEF, 32'h0};
    vecs[7]  = '{1'b0, 3'd2, 32'h0000_0004, 32'h0,         32'h0,         0, 1, 1'b1, 1'b0, 32'h0,         32'h0};
    vecs[8]  = '{1'b0, 3'd2, 32'h0000_0002, 32'h0,         32'h0,         0, 0, 1'b0, 1'b1, 32'h0,         32'h0};
    vecs[9]  = '{1'b0, 3'd3, 32'h0000_0000, 32'h0,         32'h0,         0, 0, 1'b0, 1'b1, 32'h0,         32'h0};
    vecs[10] = '{1'b1, 3'd1, 32'h0000_0001, 32'h1234,      32'h0,         0, 0, 1'b0, 1'b1, 32'h0,         32'h0};
    vecs[11] = '{1'b0, 3'd1, 32'h0000_0000, 32'h0,         32'h11223344, 0, 0, 1'b0, 1'b0, 32'h0,         32'h00003344};
    step();
    step();
    chk_reset("reset");
    chk("reset.hburst", HBURST, 32'd0);
    chk("reset.hprot", HPROT, 32'd3);
    chk("reset.hmastlock", HMASTLOCK, 32'd0);
    HRESETn = 1'b1;
    step();
    for (int i = 0; i < 12; i++) run(vecs[i], i);
    // response back-pressure: held response stays stable and no new command is taken
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_size = 3'd0; cmd_addr = 32'h3; rsp_ready = 1'b0;
    HREADY = 1'b1; HRDATA = 32'h11223344;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    HRDATA = 32'hFFFFFFFF;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_size = 3'd2; cmd_addr = 32'h40;
    for (int i = 0; i < 5; i++) begin
      chk("bp.rsp_valid", rsp_valid, 32'd1);
      chk("bp.rsp_rdata", rsp_rdata, 32'h11);
      chk("bp.rsp_err", rsp_err, 32'd0);
      chk("bp.cmd_ready", cmd_ready, 32'd0);
      chk("bp.htrans", HTRANS, 32'd0);
      step();
    end
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    chk("bp.still_valid", rsp_valid, 32'd1);
    step();
    chk("bp.rsp_done", rsp_valid, 32'd0);
    chk("bp.no_queued", HTRANS, 32'd0);
    chk("bp.idle", cmd_ready, 32'd1);
    // asynchronous reset while stalled in the data phase
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_size = 3'd2; cmd_addr = 32'h100; cmd_wdata = 32'h01020304;
    step();
    cmd_valid = 1'b0;
    step();
    HREADY = 1'b0;
    step();
    chk("rst.in_data", busy, 32'd1);
    HRESETn = 1'b0;
    #1;
    chk_reset("rst");
    HRESETn = 1'b1; HREADY = 1'b1;
    step();
    chk("rst.after_idle", cmd_ready, 32'd1);
    chk("rst.after_no_rsp", rsp_valid, 32'd0);
`ifdef AHB3_CMD_MASTER_TIMEOUT_EN
    // data-phase timeout then drain of the hung slave
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_size = 3'd2; cmd_addr = 32'h0; rsp_ready = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    HREADY = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk("to.no_rsp", rsp_valid, 32'd0);
      step();
    end
    chk("to.no_rsp_last", rsp_valid, 32'd0);
    step();
    chk("to.rsp_valid", rsp_valid, 32'd1);
    chk("to.rsp_err", rsp_err, 32'd1);
    chk("to.rsp_rdata", rsp_rdata, 32'd0);
    step();
    for (int i = 0; i < 3; i++) begin
      chk("to.hung_busy", busy, 32'd1);
      chk("to.hung_ready", cmd_ready, 32'd0);
      chk("to.hung_rsp", rsp_valid, 32'd0);
      step();
    end
    HREADY = 1'b1;
    step();
    chk("to.idle_ready", cmd_ready, 32'd1);
    chk("to.idle_busy", busy, 32'd0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
